// File: rtl/timer_pkg.sv
// Shared types and default sizing for the multi-channel down-timer.
package timer_pkg;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  localparam int DEF_NCH   = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_PSC_W = 5;

endpackage

// File: rtl/timer_channel.sv
// One down-counting channel: load/arm, decrement on qualified ticks,
// terminal-count pulse, optional auto-reload.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             en,
  input  mode_e            mode,
  input  logic             load,
  input  logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] cnt,
  output logic             done,
  output logic             busy
);

  logic act;
  assign act = tick && busy && en;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Load has priority over any coinciding tick; reload of 0 disarms.
        cnt  <= reload;
        busy <= (reload != '0);
      end else if (act) begin
        if (cnt > WIDTH'(1)) begin
          cnt <= cnt - WIDTH'(1);
        end else if (cnt == WIDTH'(1)) begin
          done <= 1'b1;
          if (mode == MODE_PERIODIC && reload != '0) begin
            cnt <= reload;
          end else begin
            cnt  <= '0;
            busy <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mc_down_timer.sv
// Multi-channel down timer: shared prescaler producing a registered tick,
// driving NCH independent timer_channel instances.
module mc_down_timer
  import timer_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int PSC_W = DEF_PSC_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PSC_W-1:0]          psc,
  input  logic [NCH-1:0]            en,
  input  logic [NCH-1:0]            mode,
  input  logic [NCH-1:0]            load,
  input  logic [NCH-1:0][WIDTH-1:0] reload,
  output logic                      tick,
  output logic [NCH-1:0][WIDTH-1:0] cnt,
  output logic [NCH-1:0]            done,
  output logic [NCH-1:0]            busy
);

  logic [PSC_W-1:0] pcnt;

  // ">=" rather than "==" so a psc lowered below the running count wraps
  // on the next edge instead of rolling all the way around.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (pcnt >= psc) begin
      pcnt <= '0;
      tick <= 1'b1;
    end else begin
      pcnt <= pcnt + PSC_W'(1);
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .en    (en[i]),
      .mode  (mode_e'(mode[i])),
      .load  (load[i]),
      .reload(reload[i]),
      .cnt   (cnt[i]),
      .done  (done[i]),
      .busy  (busy[i])
    );
  end

endmodule
